// File: rtl/clock_set_ctrl.sv
// Control block for the BCD time-of-day counter: 1 Hz count enable, key
// debouncing, and the hour/minute setting state machine with blink masks.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned DEB_CYCLES = 20,
  parameter int unsigned BLINK_DIV  = 250
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [1:0] cur_hour_h,
  input  logic [3:0] cur_hour_l,
  input  logic [2:0] cur_min_h,
  input  logic [3:0] cur_min_l,
  output logic       tick_en,
  output logic       load,
  output logic [1:0] ld_hour_h,
  output logic [3:0] ld_hour_l,
  output logic [2:0] ld_min_h,
  output logic [3:0] ld_min_l,
  output logic [1:0] mode,
  output logic [3:0] blank
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Key path; index 0 is the mode key, index 1 the increment key.
  logic [1:0]    keys;
  logic [1:0]    sync1, sync2;
  logic [1:0]    lvl, lvl_d;
  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    press;
  logic          press_mode, press_inc;

  assign keys = {key_inc, key_mode};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          lvl[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press      = lvl & ~lvl_d;
  assign press_mode = press[0];
  assign press_inc  = press[1];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:      if (press_mode) state_nxt = ST_SET_HOUR;
      ST_SET_HOUR: if (press_mode) state_nxt = ST_SET_MIN;
      ST_SET_MIN:  if (press_mode) state_nxt = ST_COMMIT;
      ST_COMMIT:   state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // Edit registers and their BCD successors
  logic [1:0] edit_hh, hour_nxt_h;
  logic [3:0] edit_hl, hour_nxt_l;
  logic [2:0] edit_mh, min_nxt_h;
  logic [3:0] edit_ml, min_nxt_l;

  always_comb begin
    hour_nxt_h = edit_hh;
    hour_nxt_l = edit_hl + 4'd1;
    if (edit_hh == 2'd2 && edit_hl == 4'd3) begin
      hour_nxt_h = '0;
      hour_nxt_l = '0;
    end else if (edit_hl == 4'd9) begin
      hour_nxt_h = edit_hh + 2'd1;
      hour_nxt_l = '0;
    end
  end

  always_comb begin
    min_nxt_h = edit_mh;
    min_nxt_l = edit_ml + 4'd1;
    if (edit_ml == 4'd9) begin
      min_nxt_l = '0;
      min_nxt_h = (edit_mh == 3'd5) ? 3'd0 : edit_mh + 3'd1;
    end
  end

  // Mode press takes priority, so an inc press in the same cycle is dropped.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      edit_hh <= '0;
      edit_hl <= '0;
      edit_mh <= '0;
      edit_ml <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (press_mode) begin
            edit_hh <= cur_hour_h;
            edit_hl <= cur_hour_l;
            edit_mh <= cur_min_h;
            edit_ml <= cur_min_l;
          end
        end
        ST_SET_HOUR: begin
          if (!press_mode && press_inc) begin
            edit_hh <= hour_nxt_h;
            edit_hl <= hour_nxt_l;
          end
        end
        ST_SET_MIN: begin
          if (!press_mode && press_inc) begin
            edit_mh <= min_nxt_h;
            edit_ml <= min_nxt_l;
          end
        end
        default: ;
      endcase
    end
  end

  // Load values are latched on entry to COMMIT; edits are frozen there.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ld_hour_h <= '0;
      ld_hour_l <= '0;
      ld_min_h  <= '0;
      ld_min_l  <= '0;
    end else if (state == ST_SET_MIN && press_mode) begin
      ld_hour_h <= edit_hh;
      ld_hour_l <= edit_hl;
      ld_min_h  <= edit_mh;
      ld_min_l  <= edit_ml;
    end
  end

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tick_cnt <= '0;
    end else if (state == ST_RUN && state_nxt == ST_RUN) begin
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
    end else begin
      tick_cnt <= '0;
    end
  end

  assign tick_en = (state == ST_RUN) && (tick_cnt == TW'(TICK_DIV - 1));

  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          editing;

  assign editing = (state == ST_SET_HOUR) || (state == ST_SET_MIN);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (!editing || state_nxt != state) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blank = '0;
    if (blink_ph) begin
      if (state == ST_SET_HOUR) blank = 4'b1100;
      if (state == ST_SET_MIN)  blank = 4'b0011;
    end
  end

  assign load = (state == ST_COMMIT);
  assign mode = state;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Control block for the BCD time-of-day counter (HH:MM:SS, 00:00:00–23:59:59).
- Generates the counter's 1 Hz count enable from the system clock.
- Debounces the two user keys and runs the time-setting state machine: edit hours, then minutes, then commit.
- Drives a one-cycle parallel-load request with the edited BCD values, plus per-digit blink masks for the display driver.

Parameters:
- TICK_DIV, 1000, clk cycles per count-enable pulse (≥2).
- DEB_CYCLES, 20, consecutive stable synchronized samples needed to accept a key level change (≥1).
- BLINK_DIV, 250, clk cycles per blink half-period (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  asynchronous active-low reset
- key_mode  in  1  raw mode key, active-high, asynchronous
- key_inc  in  1  raw increment key, active-high, asynchronous
- cur_hour_h  in  2  counter hour tens (0–2)
- cur_hour_l  in  4  counter hour units (0–9)
- cur_min_h  in  3  counter minute tens (0–5)
- cur_min_l  in  4  counter minute units (0–9)
- tick_en  out  1  one-cycle count enable to the counter
- load  out  1  one-cycle parallel-load strobe; counter loads ld_* and clears seconds to 00
- ld_hour_h  out  2  load value, hour tens
- ld_hour_l  out  4  load value, hour units
- ld_min_h  out  3  load value, minute tens
- ld_min_l  out  4  load value, minute units
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=COMMIT
- blank  out  4  digit blank mask {hour_h, hour_l, min_h, min_l}; 1=blank

Behaviour:
- Reset (clr=0, asynchronous): state RUN; all outputs 0; edit registers 00:00; prescaler, blink counter and blink phase 0; synchronizers, debounced levels and debounce counters 0.
- Key path (per key):
  - 2-FF synchronizer.
  - Debounce counter counts consecutive cycles where the synchronized value differs from the debounced level; it clears whenever they are equal.
  - When the count reaches DEB_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A press pulse (1 cycle) is asserted in the cycle after the debounced level rises 0→1. Releases generate no pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. tick_en=1 for the single cycle in which the count equals TICK_DIV-1; the count then wraps to 0.
  - Held at 0 in every other state, so tick_en=0 in SET_HOUR, SET_MIN and COMMIT.
  - Leaving COMMIT restarts the count at 0, so the first tick_en occurs TICK_DIV cycles after the load strobe.
- FSM (all transitions on a press pulse unless stated):
  - RUN + mode press → SET_HOUR. In the same edge the edit registers capture cur_hour_*/cur_min_*.
  - SET_HOUR + mode press → SET_MIN.
  - SET_MIN + mode press → COMMIT.
  - COMMIT → RUN unconditionally after 1 cycle. load=1 only while in COMMIT, with ld_* = edit registers.
  - ld_* hold their last value at all other times.
  - An inc press in RUN or COMMIT is ignored.
- Edit arithmetic (BCD, never binary):
  - SET_HOUR + inc press: hour +1; x9→(x+1)0; 23→00.
  - SET_MIN + inc press: minute +1; x9→(x+1)0; 59→00.
  - Mode and inc press pulses in the same cycle: mode wins, inc is dropped.
- Blink:
  - Counter runs only in SET_HOUR/SET_MIN. Phase toggles every BLINK_DIV cycles.
  - Counter and phase clear on any state change.
  - blank = 4'b1100 in SET_HOUR when phase=1; 4'b0011 in SET_MIN when phase=1; otherwise 0.
- Reset mid-edit: returns to RUN with no load strobe; edits are lost.

Test Plan (TICK_DIV=4, DEB_CYCLES=3, BLINK_DIV=8):
- Release reset, hold keys low for 20 cycles → tick_en pulses every 4th cycle, 5 pulses total; load=0; mode=0; blank=0.
- key_mode high for 2 cycles then low → no press pulse, mode stays 0. Hold high for 10 cycles → mode=1 exactly once, 6 cycles after the rise (2 sync + 3 debounce + 1 pulse).
- cur=23:58, enter SET_HOUR, one inc press → edit hour 00. Mode to SET_MIN, two inc presses → 59 then 00. Mode → one load cycle with ld = 0,0,0,0; mode returns to 0; next tick_en 4 cycles after load.
- cur=09:09: hour inc → 10; minute inc → 10. Commit → ld_hour_h=1, ld_hour_l=0, ld_min_h=1, ld_min_l=0.
- In SET_HOUR, force mode and inc press pulses in the same cycle → moves to SET_MIN, hour unchanged. blank toggles between 1100 and 0000 every 8 cycles in SET_HOUR, and between 0011 and 0000 in SET_MIN.
- Assert clr while in SET_MIN → mode=0, load never pulses, all outputs 0; after release, tick_en resumes at cycle 4.
